// File: rtl/arm_block_xfer_seq_if.sv
// ============================================================================
// Module   : arm_block_xfer_seq_if
// Purpose  : Word-access memory bus between the block-transfer sequencer and memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface arm_block_xfer_seq_if;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/arm_block_xfer_seq.sv
// ============================================================================
// Module   : arm_block_xfer_seq
// Purpose  : LDM/STM sequencer. It walks the register list, issues one word
//            access per register, then performs base writeback.
// Options  : ARM_EMPTY_RLIST_QUIRK_EN - an empty list transfers R15 with n=16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_block_xfer_seq (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 reg_list,
  input  logic [3:0]                  rn,
  input  logic [31:0]                 base,
  input  logic                        p,
  input  logic                        u,
  input  logic                        s,
  input  logic                        w,
  input  logic                        l,
  output logic                        busy,
  output logic                        done,
  output logic                        user_bank,
  arm_block_xfer_seq_if.master        mem,
  output logic [3:0]                  rf_rd_idx,
  input  logic [31:0]                 rf_rd_data,
  output logic                        rf_wr_en,
  output logic [3:0]                  rf_wr_idx,
  output logic [31:0]                 rf_wr_data,
  output logic                        wb_en,
  output logic [31:0]                 wb_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_XFER = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_list;
  logic [15:0] r_mask;
  logic [3:0]  r_rn;
  logic [31:0] r_base;
  logic        r_p;
  logic        r_u;
  logic        r_s;
  logic        r_w;
  logic        r_l;
  logic [31:0] r_addr;
  logic [31:0] r_wb_val;

  logic [15:0] w_mask_in;
  logic [15:0] w_mask_next;
  logic [4:0]  w_cnt;
  logic [4:0]  w_n;
  logic [31:0] w_span;
  logic [31:0] w_start_addr;
  logic [31:0] w_wb_calc;
  logic [3:0]  w_cur;
  logic        w_user;

`ifdef ARM_EMPTY_RLIST_QUIRK_EN
  assign w_mask_in = (reg_list == 16'd0) ? 16'h8000 : reg_list;
  assign w_n       = (r_list == 16'd0) ? 5'd16 : w_cnt;
`else
  assign w_mask_in = reg_list;
  assign w_n       = w_cnt;
`endif

  always_comb begin
    w_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      w_cnt = w_cnt + {4'd0, r_mask[i]};
    end
  end

  // Scanning downward leaves the lowest set bit as the final winner.
  always_comb begin
    w_cur = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_cur = 4'(i);
      end
    end
  end

  assign w_mask_next = r_mask & (r_mask - 16'd1);
  assign w_span      = {25'd0, w_n, 2'b00};
  assign w_wb_calc   = r_u ? (r_base + w_span) : (r_base - w_span);
  assign w_user      = r_s & ~(r_l & r_list[15]);

  always_comb begin
    case ({r_p, r_u})
      2'b01:   w_start_addr = r_base;
      2'b11:   w_start_addr = r_base + 32'd4;
      2'b00:   w_start_addr = r_base - w_span + 32'd4;
      default: w_start_addr = r_base - w_span;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_list   <= 16'd0;
      r_mask   <= 16'd0;
      r_rn     <= 4'd0;
      r_base   <= 32'd0;
      r_p      <= 1'b0;
      r_u      <= 1'b0;
      r_s      <= 1'b0;
      r_w      <= 1'b0;
      r_l      <= 1'b0;
      r_addr   <= 32'd0;
      r_wb_val <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_list <= reg_list;
            r_mask <= w_mask_in;
            r_rn   <= rn;
            r_base <= {base[31:2], 2'b00};
            r_p    <= p;
            r_u    <= u;
            r_s    <= s;
            r_w    <= w;
            r_l    <= l;
          end
        end
        S_CALC: begin
          r_addr   <= w_start_addr;
          r_wb_val <= w_wb_calc;
        end
        S_XFER: begin
          if (mem.mem_ack) begin
            r_mask <= w_mask_next;
            r_addr <= r_addr + 32'd4;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // All outputs are decoded from the state, so reset forces them low at once.
  always_comb begin
    w_state_nxt   = r_state;
    busy          = 1'b0;
    done          = 1'b0;
    user_bank     = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_write = 1'b0;
    mem.mem_addr  = 32'd0;
    mem.mem_wdata = 32'd0;
    rf_rd_idx     = 4'd0;
    rf_wr_en      = 1'b0;
    rf_wr_idx     = 4'd0;
    rf_wr_data    = 32'd0;
    wb_en         = 1'b0;
    wb_data       = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        busy      = 1'b1;
        user_bank = w_user;
        w_state_nxt = (w_n == 5'd0) ? S_WB : S_XFER;
      end
      S_XFER: begin
        busy          = 1'b1;
        user_bank     = w_user;
        mem.mem_req   = 1'b1;
        mem.mem_write = ~r_l;
        mem.mem_addr  = r_addr;
        if (!r_l) begin
          rf_rd_idx     = w_cur;
          mem.mem_wdata = rf_rd_data;
        end
        if (mem.mem_ack) begin
          if (r_l) begin
            rf_wr_en   = 1'b1;
            rf_wr_idx  = w_cur;
            rf_wr_data = mem.mem_rdata;
          end
          if (w_mask_next == 16'd0) begin
            w_state_nxt = S_WB;
          end
        end
      end
      default: begin
        busy        = 1'b1;
        done        = 1'b1;
        user_bank   = w_user;
        wb_en       = r_w & ~(r_l & r_list[r_rn]);
        wb_data     = r_wb_val;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
